// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Word width, PC step, reset PC default and FSM encoding.
package instr_fetch_unit_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_INC       = 16'd2;
    localparam word_t RESET_PC_DEF = 16'h0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch buffer: circular FIFO of (instruction, pc+2) pairs.
// Flush wins over push and pop; storage is reset to zero.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [15:0]   push_instr,
    input  logic [15:0]   push_pc2,
    input  logic          pop,
    input  logic          flush,
    output logic [15:0]   head_instr,
    output logic [15:0]   head_pc2,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    word_t         instr_mem_q [DEPTH];
    word_t         instr_mem_d [DEPTH];
    word_t         pc2_mem_q   [DEPTH];
    word_t         pc2_mem_d   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        instr_mem_d = instr_mem_q;
        pc2_mem_d   = pc2_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        if (push) begin
            instr_mem_d[wr_ptr_q] = push_instr;
            pc2_mem_d[wr_ptr_q]   = push_pc2;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc2_mem_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            instr_mem_q <= instr_mem_d;
            pc2_mem_q   <= pc2_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign head_pc2   = pc2_mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited sequential prefetch with
// redirect flush and in-flight response dropping.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int    FIFO_DEPTH = 2,
    parameter word_t RESET_PC   = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [15:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc2
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    word_t         fetch_pc_q, fetch_pc_d;
    word_t         rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] fifo_count;
    logic          req_valid;
    logic          req_hs;
    logic          rsp_eff;
    logic          push;
    logic          pop;
    word_t         push_pc2;

    // Credit covers both in-flight requests and buffered entries.
    always_comb begin
        req_valid = (state_q == RUN)
                    && ((int'(outst_q) + int'(fifo_count)) < FIFO_DEPTH)
                    && !redirect_valid;
        req_hs    = req_valid && imem_req_ready;
        rsp_eff   = imem_rsp_valid && (outst_q != '0);
        pop       = instr_valid && instr_ready;
        push      = rsp_eff && (drop_q == '0) && !redirect_valid;
        push_pc2  = rsp_pc_q + PC_INC;

        state_d    = RUN;
        outst_d    = outst_q + CW'(req_hs) - CW'(rsp_eff);
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;

        if (req_hs) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
        if (push) begin
            rsp_pc_d = push_pc2;
        end
        if (rsp_eff && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 16'hFFFE;
            rsp_pc_d   = redirect_pc & 16'hFFFE;
            drop_d     = outst_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imem_rsp_data),
        .push_pc2   (push_pc2),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_instr (instr),
        .head_pc2   (instr_pc2),
        .count      (fifo_count)
    );

    assign imem_req_valid = req_valid;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = (fifo_count != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// random traffic checked against a program-order reference model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc2;

    instr_fetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc2      (instr_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          nreq   = 0;
    int          npop   = 0;
    logic [15:0] mq[$];
    logic [15:0] exp_pc = 16'h0000;
    bit          last_req_v;
    logic [15:0] last_addr;
    bit          pend = 1'b0;
    logic [15:0] pend_addr;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check model, clock, update memory model.
    task automatic cyc(input bit rdy, input bit irdy, input bit rsp_en,
                       input bit redir, input logic [15:0] rpc,
                       input bit stale = 1'b0);
        bit rsp_now;
        bit hs;
        @(negedge clk);
        imem_req_ready = rdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp_now        = rsp_en && (mq.size() > 0);
        imem_rsp_valid = rsp_now || stale;
        imem_rsp_data  = rsp_now ? mem_data(mq[0]) : 16'hDEAD;
        #1;
        last_req_v = imem_req_valid;
        last_addr  = imem_addr;
        if (pend && !redir) begin
            chk("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("hold_addr", {16'd0, imem_addr}, {16'd0, pend_addr});
        end
        if (imem_req_valid)
            chk("credit", {31'd0, mq.size() < DEPTH}, 32'd1);
        if (instr_valid && irdy) begin
            chk("stream_pc2", {16'd0, instr_pc2}, {16'd0, exp_pc + 16'd2});
            chk("stream_instr", {16'd0, instr}, {16'd0, mem_data(exp_pc)});
            exp_pc = exp_pc + 16'd2;
            npop++;
        end
        if (redir) exp_pc = rpc & 16'hFFFE;
        hs        = imem_req_valid && rdy;
        pend      = imem_req_valid && !rdy && !redir;
        pend_addr = imem_addr;
        @(posedge clk);
        if (rsp_now) void'(mq.pop_front());
        if (hs) begin
            mq.push_back(last_addr);
            nreq++;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((mq.size() > 0 || instr_valid) && k < 20) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
            k++;
        end
        #1;
        chk("drain_done", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_addr"}, {16'd0, imem_addr}, 32'h0000);
        chk({tag, "_instr"}, {16'd0, instr}, 32'h0000);
        chk({tag, "_pc2"}, {16'd0, instr_pc2}, 32'h0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        logic [15:0] s_instr;
        logic [15:0] s_pc2;
        int          p0;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0;
        instr_ready    = 1'b0;
        #1;
        check_reset_outputs("rst0");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Sequential fetch, single-cycle memory
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("boot_no_req", {31'd0, last_req_v}, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("first_req_v", {31'd0, last_req_v}, 32'd1);
        chk("first_addr", {16'd0, last_addr}, 32'h0000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("second_addr", {16'd0, last_addr}, 32'h0002);
        #1;
        chk("lat_valid", {31'd0, instr_valid}, 32'd1);
        chk("lat_pc2", {16'd0, instr_pc2}, 32'h0002);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("third_addr", {16'd0, last_addr}, 32'h0004);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

        // Consumer stall for 10 cycles
        r0 = nreq;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        #1;
        s_instr = instr;
        s_pc2   = instr_pc2;
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        #1;
        chk("stall_reqs", {31'd0, (nreq - r0) <= 2}, 32'd1);
        chk("stall_instr", {16'd0, instr}, {16'd0, s_instr});
        chk("stall_pc2", {16'd0, instr_pc2}, {16'd0, s_pc2});
        chk("stall_req_v", {31'd0, imem_req_valid}, 32'd0);
        p0 = npop;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        #1;
        chk("stall_two_entries", npop - p0, 32'd2);
        chk("stall_empty", {31'd0, instr_valid}, 32'd0);
        drain();

        // Redirect to odd address with one request in flight
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0041);
        chk("redir_no_req", {31'd0, last_req_v}, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("redir_req_v", {31'd0, last_req_v}, 32'd1);
        chk("redir_addr", {16'd0, last_addr}, 32'h0040);
        #1;
        chk("stale_dropped", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        #1;
        chk("redir_valid", {31'd0, instr_valid}, 32'd1);
        chk("redir_pc2", {16'd0, instr_pc2}, 32'h0042);
        drain();

        // Address wrap
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFE);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("wrap_addr0", {16'd0, last_addr}, 32'hFFFE);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("wrap_addr1", {16'd0, last_addr}, 32'h0000);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        drain();

        // Redirect + pop + response in the same cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        #1;
        chk("combo_pre_valid", {31'd0, instr_valid}, 32'd1);
        p0 = npop;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
        chk("combo_popped", npop - p0, 32'd1);
        #1;
        chk("combo_empty", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        #1;
        chk("combo_still_empty", {31'd0, instr_valid}, 32'd0);
        drain();

        // Asynchronous reset with two requests outstanding
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("pre_rst_outst", mq.size(), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst1");
        mq.delete();
        exp_pc = 16'h0000;
        pend   = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_boot", {31'd0, last_req_v}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_req_addr", {16'd0, last_addr}, 32'h0000);
        chk("rst_req_v", {31'd0, last_req_v}, 32'd1);
        #1;
        chk("late_ignored", {31'd0, instr_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        #1;
        chk("restart_valid", {31'd0, instr_valid}, 32'd1);
        chk("restart_pc2", {16'd0, instr_pc2}, 32'h0002);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 4) > 1,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 24) == 0,
                16'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
